// File: rtl/wb_unit_pkg.sv
// wb_unit_pkg: shared constants and types for the register-file writeback unit.
//   AW, DW, NREG  : register address width, data width, register count
//   LDQ, MAXLD    : load-return FIFO depth, maximum outstanding loads
//   ZERO_REG      : hardwired-zero register, never written nor marked busy
//   RA_REG        : link register targeted by JAL
package wb_unit_pkg;

   localparam int unsigned AW       = 5;
   localparam int unsigned DW       = 32;
   localparam int unsigned NREG     = 32;
   localparam int unsigned LDQ      = 2;
   localparam int unsigned MAXLD    = 4;
   localparam int unsigned ZERO_REG = 0;
   localparam int unsigned RA_REG   = 31;

   // Which source drives the write port this cycle.
   typedef enum logic [1:0] {
      SrcNone,
      SrcAlu,
      SrcLoad
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with full/empty flags.
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset, empties the FIFO
//   push_i   : write wdata_i (ignored when full)
//   wdata_i  : data to push
//   pop_i    : drop the head entry (ignored when empty)
//   rdata_o  : current head entry
//   full_o   : Depth entries held
//   empty_o  : no entries held
module wb_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 37
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; stale entries are never visible past empty_o.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: register-file writeback unit with busy scoreboard and load-return FIFO.
//   CLK, RST              : clock; synchronous active-low reset
//   Iss_valid/dst/load    : decode issues a register-writing instruction
//   Q_rs, Q_rt            : sources of the instruction in decode
//   Stall                 : decode must hold (source busy or load limit reached)
//   Alu_valid/dst/data    : ALU result, highest priority, never back-pressured
//   Ld_valid/dst/data     : load return data into the FIFO
//   Ld_ready              : FIFO can accept a load this cycle
//   We, Wadr, Wdata       : registered register-file write port
module wb_unit
   import wb_unit_pkg::*;
#(
   parameter int unsigned NREG  = wb_unit_pkg::NREG,
   parameter int unsigned DW    = wb_unit_pkg::DW,
   parameter int unsigned AW    = wb_unit_pkg::AW,
   parameter int unsigned LDQ   = wb_unit_pkg::LDQ,
   parameter int unsigned MAXLD = wb_unit_pkg::MAXLD
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          Iss_valid,
   input  logic [AW-1:0] Iss_dst,
   input  logic          Iss_load,
   input  logic [AW-1:0] Q_rs,
   input  logic [AW-1:0] Q_rt,
   output logic          Stall,
   input  logic          Alu_valid,
   input  logic [AW-1:0] Alu_dst,
   input  logic [DW-1:0] Alu_data,
   input  logic          Ld_valid,
   output logic          Ld_ready,
   input  logic [AW-1:0] Ld_dst,
   input  logic [DW-1:0] Ld_data,
   output logic          We,
   output logic [AW-1:0] Wadr,
   output logic [DW-1:0] Wdata
);

   localparam int unsigned CW = $clog2(MAXLD + 1);
   localparam logic [AW-1:0] Zero = AW'(ZERO_REG);

   logic [NREG-1:0] busy_q, busy_d;
   logic [CW-1:0]   ld_cnt_q, ld_cnt_d;
   logic            we_q, we_d;
   logic [AW-1:0]   wadr_q, wadr_d;
   logic [DW-1:0]   wdata_q, wdata_d;

   logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [AW+DW-1:0] fifo_head;

   wb_src_e         src;
   logic [AW-1:0]   sel_dst;
   logic [DW-1:0]   sel_data;
   logic            src_busy, ld_limit, issue_ok, ld_inc, ld_dec;

   // Register 0 is excluded explicitly so a stray busy bit can never stall it.
   assign src_busy = ((Q_rs != Zero) & busy_q[Q_rs]) | ((Q_rt != Zero) & busy_q[Q_rt]);
   assign ld_limit = Iss_load & (ld_cnt_q == CW'(MAXLD));
   assign Stall    = src_busy | ld_limit;

   // Ready depends only on full, so a same-cycle pop never frees a slot early.
   assign Ld_ready  = ~fifo_full & RST;
   assign fifo_push = Ld_valid & Ld_ready;

   wb_fifo #(
      .Depth (LDQ),
      .Width (AW + DW)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .push_i  (fifo_push),
      .wdata_i ({Ld_dst, Ld_data}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Arbitration: ALU first, otherwise drain the FIFO head.
   always_comb begin
      src      = SrcNone;
      fifo_pop = 1'b0;
      sel_dst  = '0;
      sel_data = '0;
      if (Alu_valid) begin
         src      = SrcAlu;
         sel_dst  = Alu_dst;
         sel_data = Alu_data;
      end else if (!fifo_empty) begin
         src      = SrcLoad;
         fifo_pop = 1'b1;
         sel_dst  = fifo_head[AW+DW-1:DW];
         sel_data = fifo_head[DW-1:0];
      end
   end

   // Writes to register 0 consume the source but leave the port untouched.
   always_comb begin
      we_d    = (src != SrcNone) && (sel_dst != Zero);
      wadr_d  = we_d ? sel_dst  : wadr_q;
      wdata_d = we_d ? sel_data : wdata_q;
   end

   always_comb begin
      issue_ok = Iss_valid & ~Stall;
      ld_inc   = issue_ok & Iss_load;
      ld_dec   = fifo_pop & (ld_cnt_q != '0);
      ld_cnt_d = ld_cnt_q;
      case ({ld_inc, ld_dec})
         2'b10:   ld_cnt_d = ld_cnt_q + 1'b1;
         2'b01:   ld_cnt_d = ld_cnt_q - 1'b1;
         default: ld_cnt_d = ld_cnt_q;
      endcase
   end

   // Clear before set so a same-edge reissue to the written register stays busy.
   always_comb begin
      busy_d = busy_q;
      if (we_q) busy_d[wadr_q] = 1'b0;
      if (issue_ok && (Iss_dst != Zero)) busy_d[Iss_dst] = 1'b1;
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         busy_q   <= '0;
         ld_cnt_q <= '0;
         we_q     <= 1'b0;
         wadr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         busy_q   <= busy_d;
         ld_cnt_q <= ld_cnt_d;
         we_q     <= we_d;
         wadr_q   <= wadr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign We    = we_q;
   assign Wadr  = wadr_q;
   assign Wdata = wdata_q;

endmodule
